// File: rtl/pixel_array_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pixel_array_sequencer
// Purpose  : Frame sequencer for the pixel array (erase/expose/convert/read)
//            with ramp counter drive and valid/ready row readout.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_array_sequencer #(
    parameter int ROWS         = 4,
    parameter int CNT_W        = 8,
    parameter int EXP_W        = 16,
    parameter int ERASE_CYCLES = 5
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic                                continuous,
    input  logic [EXP_W-1:0]                    expose_time,
    output logic                                erase,
    output logic                                expose,
    output logic                                convert,
    output logic                                read,
    output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] row_sel,
    output logic [CNT_W-1:0]                    pixel_counter,
    output logic                                ramp_en,
    output logic                                bias_en,
    output logic                                data_valid,
    input  logic                                data_ready,
    output logic                                busy,
    output logic                                frame_done
);

    localparam int c_row_w = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int c_era_w = $clog2(ERASE_CYCLES + 1);
    localparam int c_tmp_w = (EXP_W > CNT_W) ? EXP_W : CNT_W;
    localparam int c_tim_w = (c_tmp_w > c_era_w) ? c_tmp_w : c_era_w;

    localparam logic [c_tim_w-1:0] c_erase_last = c_tim_w'(ERASE_CYCLES - 1);
    localparam logic [c_tim_w-1:0] c_conv_last  = c_tim_w'((2 ** CNT_W) - 1);
    localparam logic [c_tim_w-1:0] c_tim_one    = c_tim_w'(1);
    localparam logic [c_row_w-1:0] c_row_last   = c_row_w'(ROWS - 1);
    localparam logic [c_row_w-1:0] c_row_one    = c_row_w'(1);
    localparam logic [EXP_W-1:0]   c_exp_one    = EXP_W'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ERASE   = 3'd1,
        S_EXPOSE  = 3'd2,
        S_CONVERT = 3'd3,
        S_READ    = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [c_tim_w-1:0]   tim_q, tim_d;
    logic [EXP_W-1:0]     exp_len_q, exp_len_d;
    logic [c_row_w-1:0]   row_q, row_d;

    logic                 erase_q, erase_d;
    logic                 expose_q, expose_d;
    logic                 convert_q, convert_d;
    logic                 read_q, read_d;
    logic [c_row_w-1:0]   row_sel_q, row_sel_d;
    logic [CNT_W-1:0]     pixel_counter_q, pixel_counter_d;
    logic                 busy_q, busy_d;
    logic                 frame_done_q, frame_done_d;

    logic [EXP_W-1:0]     w_exp_len_in;
    logic [c_tim_w-1:0]   w_exp_last;

    always_comb begin
        state_d      = state_q;
        tim_d        = tim_q;
        exp_len_d    = exp_len_q;
        row_d        = row_q;
        frame_done_d = 1'b0;

        // A zero exposure request still yields one expose cycle.
        w_exp_len_in = (expose_time == '0) ? c_exp_one : expose_time;
        w_exp_last   = c_tim_w'(exp_len_q) - c_tim_one;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_ERASE;
                    tim_d     = '0;
                    exp_len_d = w_exp_len_in;
                    row_d     = '0;
                end
            end
            S_ERASE: begin
                if (tim_q == c_erase_last) begin
                    state_d = S_EXPOSE;
                    tim_d   = '0;
                end else begin
                    tim_d = tim_q + c_tim_one;
                end
            end
            S_EXPOSE: begin
                if (tim_q == w_exp_last) begin
                    state_d = S_CONVERT;
                    tim_d   = '0;
                end else begin
                    tim_d = tim_q + c_tim_one;
                end
            end
            S_CONVERT: begin
                if (tim_q == c_conv_last) begin
                    state_d = S_READ;
                    tim_d   = '0;
                    row_d   = '0;
                end else begin
                    tim_d = tim_q + c_tim_one;
                end
            end
            S_READ: begin
                if (data_ready) begin
                    if (row_q == c_row_last) begin
                        frame_done_d = 1'b1;
                        row_d        = '0;
                        tim_d        = '0;
                        if (continuous) begin
                            state_d   = S_ERASE;
                            exp_len_d = w_exp_len_in;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        row_d = row_q + c_row_one;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tim_d   = '0;
                row_d   = '0;
            end
        endcase

        // Outputs are decoded from the next state so they register in step with it.
        erase_d         = (state_d == S_ERASE);
        expose_d        = (state_d == S_EXPOSE);
        convert_d       = (state_d == S_CONVERT);
        read_d          = (state_d == S_READ);
        busy_d          = (state_d != S_IDLE);
        row_sel_d       = (state_d == S_READ) ? row_d : '0;
        pixel_counter_d = (state_d == S_CONVERT) ? tim_d[CNT_W-1:0] : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= S_IDLE;
            tim_q           <= '0;
            exp_len_q       <= '0;
            row_q           <= '0;
            erase_q         <= 1'b0;
            expose_q        <= 1'b0;
            convert_q       <= 1'b0;
            read_q          <= 1'b0;
            row_sel_q       <= '0;
            pixel_counter_q <= '0;
            busy_q          <= 1'b0;
            frame_done_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            tim_q           <= tim_d;
            exp_len_q       <= exp_len_d;
            row_q           <= row_d;
            erase_q         <= erase_d;
            expose_q        <= expose_d;
            convert_q       <= convert_d;
            read_q          <= read_d;
            row_sel_q       <= row_sel_d;
            pixel_counter_q <= pixel_counter_d;
            busy_q          <= busy_d;
            frame_done_q    <= frame_done_d;
        end
    end

    assign erase         = erase_q;
    assign expose        = expose_q;
    assign convert       = convert_q;
    assign read          = read_q;
    assign row_sel       = row_sel_q;
    assign pixel_counter = pixel_counter_q;
    assign ramp_en       = convert_q;
    assign bias_en       = expose_q;
    assign data_valid    = read_q;
    assign busy          = busy_q;
    assign frame_done    = frame_done_q;

endmodule
`default_nettype wire
